// File: rtl/of_accum_drain_bank.sv
// Output-feature buffer bank: stores NUM_BANKS-lane psum vectors, accumulates them over several
// passes, then drains ReLU/shift/saturated results through a valid/ready port.
`timescale 1ns/1ps
module of_accum_drain_bank #(
    parameter int NUM_BANKS   = 15,
    parameter int IN_WIDTH    = 16,
    parameter int ACC_WIDTH   = 24,
    parameter int OUT_WIDTH   = 8,
    parameter int DEPTH_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [DEPTH_WIDTH:0]        cfg_len,
    input  logic [7:0]                  cfg_passes,
    input  logic [4:0]                  cfg_shift,
    input  logic                        cfg_relu,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  in_data [NUM_BANKS],
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out_data [NUM_BANKS],
    output logic                        busy,
    output logic                        done,
    output logic                        sat_flag
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] MAX_LEN = (DEPTH_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FILL, ACC, DRAIN} state_t;

    state_t                      state, state_d;
    logic [DEPTH_WIDTH:0]        vec_cnt, len_q;
    logic [7:0]                  pass_cnt, passes_q;
    logic [4:0]                  shift_q;
    logic                        relu_q;
    logic                        in_fire, out_fire, vec_last, len_bad;
    logic                        acc_ovf_any, out_ovf_any;
    logic [DEPTH_WIDTH-1:0]      addr;

    logic signed [ACC_WIDTH-1:0] mem      [DEPTH][NUM_BANKS];
    logic signed [ACC_WIDTH-1:0] in_sext  [NUM_BANKS];
    logic signed [ACC_WIDTH:0]   acc_sum  [NUM_BANKS];
    logic signed [ACC_WIDTH-1:0] acc_sat  [NUM_BANKS];
    logic signed [ACC_WIDTH-1:0] post_sh  [NUM_BANKS];

    function automatic logic acc_ovf(input logic signed [ACC_WIDTH:0] x);
        return x[ACC_WIDTH] != x[ACC_WIDTH-1];
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic signed [ACC_WIDTH:0] x);
        if (acc_ovf(x))
            return x[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        return x[ACC_WIDTH-1:0];
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] post_shift(input logic signed [ACC_WIDTH-1:0] x,
                                                              input logic relu, input logic [4:0] sh);
        logic signed [ACC_WIDTH-1:0] r;
        r = (relu && x[ACC_WIDTH-1]) ? '0 : x;
        return r >>> sh;
    endfunction

    // Fits in OUT_WIDTH only when every bit above the output sign bit matches it.
    function automatic logic out_ovf(input logic signed [ACC_WIDTH-1:0] x);
        logic [ACC_WIDTH-OUT_WIDTH:0] top;
        top = x[ACC_WIDTH-1:OUT_WIDTH-1];
        return !((&top) || !(|top));
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] sat_out(input logic signed [ACC_WIDTH-1:0] x);
        if (out_ovf(x))
            return x[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        return x[OUT_WIDTH-1:0];
    endfunction

    assign addr = vec_cnt[DEPTH_WIDTH-1:0];

    always_comb begin
        acc_ovf_any = 1'b0;
        out_ovf_any = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            in_sext[i] = ACC_WIDTH'(in_data[i]);
            acc_sum[i] = (ACC_WIDTH+1)'(in_sext[i]) + (ACC_WIDTH+1)'(mem[addr][i]);
            acc_sat[i] = sat_acc(acc_sum[i]);
            if (acc_ovf(acc_sum[i]))
                acc_ovf_any = 1'b1;
            post_sh[i] = post_shift(mem[addr][i], relu_q, shift_q);
            if (out_ovf(post_sh[i]))
                out_ovf_any = 1'b1;
            out_data[i] = (state == DRAIN) ? sat_out(post_sh[i]) : '0;
        end
    end

    always_comb begin
        state_d   = state;
        in_ready  = (state == FILL) || (state == ACC);
        out_valid = (state == DRAIN);
        busy      = (state != IDLE);
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        vec_last  = (vec_cnt == len_q - 1'b1);
        len_bad   = (cfg_len == '0) || (cfg_len > MAX_LEN);
        case (state)
            IDLE:  if (start && !len_bad) state_d = FILL;
            FILL:  if (in_fire && vec_last) state_d = (passes_q <= 8'd1) ? DRAIN : ACC;
            ACC:   if (in_fire && vec_last && (pass_cnt + 8'd1 == passes_q)) state_d = DRAIN;
            DRAIN: if (out_fire && vec_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort)
            state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            vec_cnt  <= '0;
            pass_cnt <= '0;
            len_q    <= '0;
            passes_q <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            done     <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            state <= state_d;
            done  <= 1'b0;
            if (abort) begin
                vec_cnt  <= '0;
                pass_cnt <= '0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        len_q    <= cfg_len;
                        passes_q <= (cfg_passes == 8'd0) ? 8'd1 : cfg_passes;
                        shift_q  <= cfg_shift;
                        relu_q   <= cfg_relu;
                        sat_flag <= 1'b0;
                        vec_cnt  <= '0;
                        pass_cnt <= 8'd1;
                        done     <= len_bad;
                    end
                    FILL: if (in_fire)
                        vec_cnt <= vec_last ? '0 : vec_cnt + 1'b1;
                    ACC: if (in_fire) begin
                        if (acc_ovf_any)
                            sat_flag <= 1'b1;
                        if (vec_last) begin
                            vec_cnt  <= '0;
                            pass_cnt <= pass_cnt + 8'd1;
                        end else begin
                            vec_cnt <= vec_cnt + 1'b1;
                        end
                    end
                    DRAIN: if (out_fire) begin
                        if (out_ovf_any)
                            sat_flag <= 1'b1;
                        if (vec_last) begin
                            vec_cnt  <= '0;
                            pass_cnt <= '0;
                            done     <= 1'b1;
                        end else begin
                            vec_cnt <= vec_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Entry storage: FILL overwrites, ACC adds with saturation; never reset.
    always_ff @(posedge clk) begin
        if (in_fire && !abort)
            for (int i = 0; i < NUM_BANKS; i++)
                mem[addr][i] <= (state == FILL) ? in_sext[i] : acc_sat[i];
    end

endmodule

// File: tb/tb_of_accum_drain_bank.sv
// Scoreboard bench for of_accum_drain_bank: stimulus pushes hand-computed output vectors,
// a negedge monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_of_accum_drain_bank;
    localparam int NB = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0, abort = 1'b0;
    logic [4:0]        cfg_len = '0;
    logic [7:0]        cfg_passes = '0;
    logic [4:0]        cfg_shift = '0;
    logic              cfg_relu = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [15:0] in_data [NB];
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic signed [7:0] out_data [NB];
    logic              busy, done, sat_flag;

    int checks = 0, errors = 0, done_cnt = 0;
    int rdy_mode = 0;
    logic [NB*8-1:0] exp_q [$];

    of_accum_drain_bank dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_len(cfg_len), .cfg_passes(cfg_passes), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [NB*8-1:0] act, input logic [NB*8-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NB*8-1:0] pack_out();
        logic [NB*8-1:0] p;
        for (int i = 0; i < NB; i++) p[i*8 +: 8] = out_data[i];
        return p;
    endfunction

    // out_ready driver: 0 = always 1, 1 = toggle each cycle, 2 = held low
    initial forever begin
        @(posedge clk); #1;
        case (rdy_mode)
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // Monitor / scoreboard
    initial begin
        logic            stalled = 1'b0, prev_done = 1'b0;
        logic [NB*8-1:0] held = '0, cur;
        forever begin
            @(negedge clk);
            cur = pack_out();
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled) chk("stall_hold", {out_valid, cur}, {1'b1, held});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_out", cur, 'x);
                    else chk("out_vec", cur, exp_q.pop_front());
                end
                if (!out_valid) chk("out_zero_idle", cur, '0);
                stalled = out_valid && !out_ready;
                held = cur;
            end
            if (done) begin
                done_cnt++;
                chk("done_width", prev_done, 1'b0);
            end
            prev_done = done;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic start_job(input int len, input int passes, input int sh, input logic relu);
        @(posedge clk); #1;
        cfg_len = 5'(len); cfg_passes = 8'(passes); cfg_shift = 5'(sh); cfg_relu = relu;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_vec(input logic [NB*16-1:0] v, input int gap);
        int n = 0;
        for (int i = 0; i < NB; i++) in_data[i] = v[i*16 +: 16];
        in_valid = 1'b1;
        do begin @(negedge clk); n++; end while (!in_ready && n < 200);
        chk("in_ready_wait", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 2000);
        chk("idle_wait", busy, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [NB*16-1:0] vin;
        logic [NB*8-1:0]  ve;
        int vals[4] = '{5, -3, 127, -128};
        int d0;
        for (int i = 0; i < NB; i++) in_data[i] = '0;

        // Reset state
        @(negedge clk);
        chk("rst_ctrl", {in_ready, out_valid, busy, done, sat_flag}, '0);
        chk("rst_out_data", pack_out(), '0);
        @(posedge clk); #1 rst = 1'b0;

        // 1: reset in the middle of DRAIN
        rdy_mode = 2;
        start_job(4, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NB; i++) vin[i*16 +: 16] = 16'(k + i);
            send_vec(vin, 0);
        end
        @(negedge clk);
        chk("drain_valid", {out_valid, busy}, 2'b11);
        d0 = done_cnt;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_ctrl", {in_ready, out_valid, busy, done, sat_flag}, '0);
        chk("midrst_out_data", pack_out(), '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        rdy_mode = 0;
        chk("midrst_no_done", done_cnt, d0);

        // 2: single pass pass-through
        d0 = done_cnt;
        start_job(4, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NB; i++) begin
                vin[i*16 +: 16] = 16'(vals[(i + k) % 4]);
                ve[i*8 +: 8]    = 8'(vals[(i + k) % 4]);
            end
            exp_q.push_back(ve);
            send_vec(vin, 0);
        end
        wait_idle();
        chk("t2_done_once", done_cnt, d0 + 1);
        chk("t2_sat_clear", sat_flag, 1'b0);

        // 3: 16 entries, 3 passes of 1000 -> 3000 >>> 4 = 187 -> 127 saturated
        d0 = done_cnt;
        start_job(16, 3, 4, 0);
        for (int i = 0; i < NB; i++) vin[i*16 +: 16] = 16'sd1000;
        for (int k = 0; k < 16; k++) exp_q.push_back({NB{8'sd127}});
        for (int k = 0; k < 48; k++) send_vec(vin, 0);
        wait_idle();
        chk("t3_done_once", done_cnt, d0 + 1);
        chk("t3_sat_flag", sat_flag, 1'b1);

        // 4: relu + shift 2: 40 -> 10, 7 -> 1, -50 -> 0
        d0 = done_cnt;
        start_job(1, 0, 2, 1);
        vin = '0; ve = '0;
        vin[0*16 +: 16] = 16'sd40;  ve[0*8 +: 8] = 8'sd10;
        vin[1*16 +: 16] = 16'sd7;   ve[1*8 +: 8] = 8'sd1;
        vin[2*16 +: 16] = -16'sd50; ve[2*8 +: 8] = 8'sd0;
        exp_q.push_back(ve);
        send_vec(vin, 0);
        wait_idle();
        chk("t4_done_once", done_cnt, d0 + 1);
        chk("t4_sat_cleared", sat_flag, 1'b0);

        // 5: input gaps and toggling out_ready
        d0 = done_cnt;
        rdy_mode = 1;
        start_job(5, 1, 0, 0);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < NB; i++) begin
                vin[i*16 +: 16] = 16'(10 * k - i);
                ve[i*8 +: 8]    = 8'(10 * k - i);
            end
            exp_q.push_back(ve);
            send_vec(vin, k % 3);
        end
        wait_idle();
        rdy_mode = 0;
        chk("t5_done_once", done_cnt, d0 + 1);

        // 6: abort during second pass, then start+abort, then invalid lengths
        d0 = done_cnt;
        start_job(2, 3, 0, 0);
        for (int i = 0; i < NB; i++) vin[i*16 +: 16] = 16'sd3;
        send_vec(vin, 0);
        send_vec(vin, 0);
        send_vec(vin, 0);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_idle", {busy, in_ready, out_valid}, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, d0);

        cfg_len = 5'd2; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_idle", busy, 1'b0);

        start_job(0, 1, 0, 0);
        @(negedge clk);
        chk("len0_done", {done, busy, out_valid}, 3'b100);
        @(negedge clk);
        chk("len0_done_drop", done, 1'b0);

        start_job(17, 1, 0, 0);
        @(negedge clk);
        chk("len17_done", {done, busy, out_valid}, 3'b100);
        @(posedge clk); #1;
        chk("t6_done_count", done_cnt, d0 + 2);

        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
